// File: rtl/core_pkg.sv
// -----------------------------------------------------------------------------
// core_pkg
// Types and constants shared by the core pipeline control blocks.
//   fwd_sel_t       : encoding of the 3-input EX forwarding mux selects. It is
//                     shared with the EX datapath muxes. Bit 1 has priority
//                     over bit 0 at the mux.
//   RESULT_LOAD     : resultsrc encoding that marks a load instruction.
//   REG_AW_DEFAULT  : default register-address width (32 architectural regs).
// -----------------------------------------------------------------------------
package core_pkg;

  localparam int REG_AW_DEFAULT = 5;

  localparam logic [1:0] RESULT_LOAD = 2'b01;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_t;

endpackage : core_pkg

// File: rtl/hazard_shadow_pipe.sv
// -----------------------------------------------------------------------------
// hazard_shadow_pipe
// Shadow copy of the register-usage state for the E, M and W stages. It holds
// only what hazard detection and forwarding need, not the datapath values.
//   clk, reset           : core clock, asynchronous active-high reset
//   flush_e              : replace the D->E capture with a bubble
//   rs1_d/rs2_d/rd_d     : register addresses of the instruction in D
//   regwrite_d, load_d   : D instruction writes the RF / is a load
//   rs1_e/rs2_e/rd_e     : registered E-stage register addresses
//   regwrite_e, load_e   : registered E-stage write-enable / load flag
//   rd_m, regwrite_m     : registered M-stage destination and write-enable
//   rd_w, regwrite_w     : registered W-stage destination and write-enable
// -----------------------------------------------------------------------------
module hazard_shadow_pipe #(
  parameter int REG_AW = core_pkg::REG_AW_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush_e,
  input  logic [REG_AW-1:0] rs1_d,
  input  logic [REG_AW-1:0] rs2_d,
  input  logic [REG_AW-1:0] rd_d,
  input  logic              regwrite_d,
  input  logic              load_d,
  output logic [REG_AW-1:0] rs1_e,
  output logic [REG_AW-1:0] rs2_e,
  output logic [REG_AW-1:0] rd_e,
  output logic              regwrite_e,
  output logic              load_e,
  output logic [REG_AW-1:0] rd_m,
  output logic              regwrite_m,
  output logic [REG_AW-1:0] rd_w,
  output logic              regwrite_w
);

  // M->W and E->M shift every cycle. A load-use stall does not hold E: the
  // stalled D instruction is re-presented while E receives a bubble, so the
  // load keeps moving toward W.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_w       <= '0;
      regwrite_w <= 1'b0;
      rd_m       <= '0;
      regwrite_m <= 1'b0;
      rs1_e      <= '0;
      rs2_e      <= '0;
      rd_e       <= '0;
      regwrite_e <= 1'b0;
      load_e     <= 1'b0;
    end else begin
      rd_w       <= rd_m;
      regwrite_w <= regwrite_m;
      rd_m       <= rd_e;
      regwrite_m <= regwrite_e;
      if (flush_e) begin
        rs1_e      <= '0;
        rs2_e      <= '0;
        rd_e       <= '0;
        regwrite_e <= 1'b0;
        load_e     <= 1'b0;
      end else begin
        rs1_e      <= rs1_d;
        rs2_e      <= rs2_d;
        rd_e       <= rd_d;
        regwrite_e <= regwrite_d;
        load_e     <= load_d;
      end
    end
  end

endmodule : hazard_shadow_pipe

// File: rtl/hazard_fwd_ctrl.sv
// -----------------------------------------------------------------------------
// hazard_fwd_ctrl
// Hazard and forwarding controller for the 5-stage core. Drives the EX operand
// forwarding selects, detects load-use hazards, produces stall/flush controls
// for the F/D/E pipeline registers and counts stalled cycles.
//   clk, reset            : core clock, asynchronous active-high reset
//   rs1_d, rs2_d, rd_d    : register addresses of the instruction in D
//   regwrite_d            : D instruction writes the register file
//   resultsrc_d           : D result source (RESULT_LOAD marks a load)
//   pc_src_e              : taken branch/jump resolved in EX
//   forward_a_e/b_e       : EX operand A/B mux selects (fwd_sel_t encoding)
//   stall_f, stall_d      : hold PC / hold IF/ID register
//   flush_d, flush_e      : clear IF/ID / clear ID/EX register
//   stall_cnt             : saturating count of stalled cycles
// -----------------------------------------------------------------------------
module hazard_fwd_ctrl
  import core_pkg::*;
#(
  parameter int REG_AW = core_pkg::REG_AW_DEFAULT,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [REG_AW-1:0] rs1_d,
  input  logic [REG_AW-1:0] rs2_d,
  input  logic [REG_AW-1:0] rd_d,
  input  logic              regwrite_d,
  input  logic [1:0]        resultsrc_d,
  input  logic              pc_src_e,
  output logic [1:0]        forward_a_e,
  output logic [1:0]        forward_b_e,
  output logic              stall_f,
  output logic              stall_d,
  output logic              flush_d,
  output logic              flush_e,
  output logic [CNT_W-1:0]  stall_cnt
);

  logic [REG_AW-1:0] rs1_e;
  logic [REG_AW-1:0] rs2_e;
  logic [REG_AW-1:0] rd_e;
  logic              regwrite_e;
  logic              load_e;
  logic [REG_AW-1:0] rd_m;
  logic              regwrite_m;
  logic [REG_AW-1:0] rd_w;
  logic              regwrite_w;
  logic              load_d;
  logic              lw_stall;

  assign load_d = (resultsrc_d == RESULT_LOAD);

  hazard_shadow_pipe #(
    .REG_AW (REG_AW)
  ) u_shadow (
    .clk        (clk),
    .reset      (reset),
    .flush_e    (flush_e),
    .rs1_d      (rs1_d),
    .rs2_d      (rs2_d),
    .rd_d       (rd_d),
    .regwrite_d (regwrite_d),
    .load_d     (load_d),
    .rs1_e      (rs1_e),
    .rs2_e      (rs2_e),
    .rd_e       (rd_e),
    .regwrite_e (regwrite_e),
    .load_e     (load_e),
    .rd_m       (rd_m),
    .regwrite_m (regwrite_m),
    .rd_w       (rd_w),
    .regwrite_w (regwrite_w)
  );

  // The M stage holds the younger result, so it wins over W. x0 is hardwired
  // to zero and must always come from the register file.
  function automatic fwd_sel_t fwd_pick(
    input logic [REG_AW-1:0] src,
    input logic [REG_AW-1:0] dst_m,
    input logic              we_m,
    input logic [REG_AW-1:0] dst_w,
    input logic              we_w
  );
    fwd_sel_t sel;
    sel = FWD_RF;
    if (src != '0) begin
      if (we_m && (src == dst_m)) begin
        sel = FWD_MEM;
      end else if (we_w && (src == dst_w)) begin
        sel = FWD_WB;
      end
    end
    return sel;
  endfunction

  always_comb begin
    forward_a_e = fwd_pick(rs1_e, rd_m, regwrite_m, rd_w, regwrite_w);
    forward_b_e = fwd_pick(rs2_e, rd_m, regwrite_m, rd_w, regwrite_w);
  end

  // Source fields are compared even if the D instruction does not read them;
  // an occasional spurious stall is cheaper than decoding operand usage here.
  assign lw_stall = load_e && (rd_e != '0) && ((rs1_d == rd_e) || (rs2_d == rd_e));

  // A taken branch kills the D instruction, so stalling it would be pointless.
  assign stall_f = lw_stall && !pc_src_e;
  assign stall_d = lw_stall && !pc_src_e;
  assign flush_d = pc_src_e;
  assign flush_e = lw_stall || pc_src_e;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt <= '0;
    end else if (stall_d && (stall_cnt != {CNT_W{1'b1}})) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

endmodule : hazard_fwd_ctrl

// File: tb/tb_hazard_fwd_ctrl.sv
// -----------------------------------------------------------------------------
// tb_hazard_fwd_ctrl
// Two controllers share one stimulus stream: the default 16-bit counter build
// and a 3-bit counter build for saturation. Both are compared each cycle with
// a reference model that tracks whole instructions moving through E/M/W.
// -----------------------------------------------------------------------------
module tb_hazard_fwd_ctrl;
  import core_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] rs1_d, rs2_d, rd_d;
  logic       regwrite_d;
  logic [1:0] resultsrc_d;
  logic       pc_src_e;

  logic [1:0]  fa, fb, fa3, fb3;
  logic        sf, sd, fd, fe, sf3, sd3, fd3, fe3;
  logic [15:0] cnt;
  logic [2:0]  cnt3;

  always #5 clk = ~clk;

  hazard_fwd_ctrl dut (
    .clk(clk), .reset(reset), .rs1_d(rs1_d), .rs2_d(rs2_d), .rd_d(rd_d),
    .regwrite_d(regwrite_d), .resultsrc_d(resultsrc_d), .pc_src_e(pc_src_e),
    .forward_a_e(fa), .forward_b_e(fb), .stall_f(sf), .stall_d(sd),
    .flush_d(fd), .flush_e(fe), .stall_cnt(cnt)
  );

  hazard_fwd_ctrl #(.CNT_W(3)) dut3 (
    .clk(clk), .reset(reset), .rs1_d(rs1_d), .rs2_d(rs2_d), .rd_d(rd_d),
    .regwrite_d(regwrite_d), .resultsrc_d(resultsrc_d), .pc_src_e(pc_src_e),
    .forward_a_e(fa3), .forward_b_e(fb3), .stall_f(sf3), .stall_d(sd3),
    .flush_d(fd3), .flush_e(fe3), .stall_cnt(cnt3)
  );

  typedef struct packed {
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
    logic       we;
    logic       ld;
  } instr_t;

  // Model: the instruction occupying each stage, plus the two counters.
  instr_t m_e, m_m, m_w;
  int unsigned m_cnt, m_cnt3;
  logic exp_stall, exp_flush_e;
  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int fwd_exp(input logic [4:0] src);
    if (src == 0) return 0;
    if (m_m.we && m_m.rd == src) return 2;
    if (m_w.we && m_w.rd == src) return 1;
    return 0;
  endfunction

  function automatic bit load_use();
    return m_e.ld && m_e.rd != 0 && (rs1_d == m_e.rd || rs2_d == m_e.rd);
  endfunction

  task automatic model_clear();
    m_e = '0; m_m = '0; m_w = '0;
    m_cnt = 0; m_cnt3 = 0;
  endtask

  task automatic check_outputs(input string ph);
    bit lu;
    lu = load_use();
    exp_stall   = lu && !pc_src_e;
    exp_flush_e = lu || pc_src_e;
    chk({ph, " fwd_a"},   32'(fa),  32'(fwd_exp(m_e.rs1)));
    chk({ph, " fwd_b"},   32'(fb),  32'(fwd_exp(m_e.rs2)));
    chk({ph, " stall_f"}, 32'(sf),  32'(exp_stall));
    chk({ph, " stall_d"}, 32'(sd),  32'(exp_stall));
    chk({ph, " flush_d"}, 32'(fd),  32'(pc_src_e));
    chk({ph, " flush_e"}, 32'(fe),  32'(exp_flush_e));
    chk({ph, " cnt"},     32'(cnt), m_cnt);
    chk({ph, " cnt3"},    32'(cnt3), m_cnt3);
    chk({ph, " dut3 ctl"}, {24'(0), fa3, fb3, sf3, sd3, fd3, fe3},
        {24'(0), fa, fb, sf, sd, fd, fe});
  endtask

  // Apply D-stage inputs shortly after a rising edge and check at the
  // falling edge.
  task automatic drive(input string ph, input logic [4:0] r1, input logic [4:0] r2,
                       input logic [4:0] rd, input logic we, input logic [1:0] rs,
                       input logic pc);
    rs1_d = r1; rs2_d = r2; rd_d = rd; regwrite_d = we; resultsrc_d = rs; pc_src_e = pc;
    @(negedge clk);
    check_outputs(ph);
  endtask

  task automatic tick();
    instr_t d;
    @(posedge clk);
    d = '{rs1: rs1_d, rs2: rs2_d, rd: rd_d, we: regwrite_d, ld: (resultsrc_d == 2'b01)};
    m_w = m_m;
    m_m = m_e;
    m_e = exp_flush_e ? '0 : d;
    if (exp_stall) begin
      if (m_cnt < 65535) m_cnt++;
      if (m_cnt3 < 7) m_cnt3++;
    end
    #1;
  endtask

  task automatic step(input string ph, input logic [4:0] r1, input logic [4:0] r2,
                      input logic [4:0] rd, input logic we, input logic [1:0] rs,
                      input logic pc);
    drive(ph, r1, r2, rd, we, rs, pc);
    tick();
  endtask

  initial begin
    logic [15:0] cnt_before;
    reset = 1'b1;
    rs1_d = 0; rs2_d = 0; rd_d = 0; regwrite_d = 0; resultsrc_d = 0; pc_src_e = 0;
    model_clear();
    #1;
    check_outputs("reset");
    @(posedge clk); #1;
    reset = 1'b0;

    // EX/MEM then MEM/WB forward on operand A
    step("p2 prod", 0, 0, 5, 1, 2'b00, 0);
    step("p2 use1", 5, 0, 6, 1, 2'b00, 0);
    drive("p2 use2", 5, 0, 8, 1, 2'b00, 0);
    chk("p2 fwd_a mem", 32'(fa), 32'd2);
    tick();
    drive("p2 nop", 0, 0, 0, 0, 2'b00, 0);
    chk("p2 fwd_a wb", 32'(fa), 32'd1);
    tick();

    // Double match on x7, then x0 never forwards
    step("p3 w1", 0, 0, 7, 1, 2'b00, 0);
    step("p3 w2", 0, 0, 7, 1, 2'b00, 0);
    step("p3 rd", 0, 7, 9, 1, 2'b00, 0);
    drive("p3 chk", 0, 0, 0, 1, 2'b00, 0);
    chk("p3 fwd_b m wins", 32'(fb), 32'd2);
    tick();
    step("p3 x0", 0, 0, 0, 0, 2'b00, 0);
    drive("p3 x0 chk", 0, 0, 0, 0, 2'b00, 0);
    chk("p3 fwd_a x0", 32'(fa), 32'd0);
    chk("p3 fwd_b x0", 32'(fb), 32'd0);
    tick();

    // Load-use: one stall cycle, then a WB forward
    step("p4 ld", 0, 0, 3, 1, 2'b01, 0);
    cnt_before = cnt;
    drive("p4 use", 0, 3, 10, 1, 2'b00, 0);
    chk("p4 stall_d", 32'(sd), 32'd1);
    chk("p4 flush_e", 32'(fe), 32'd1);
    tick();
    drive("p4 held", 0, 3, 10, 1, 2'b00, 0);
    chk("p4 stall once", 32'(sd), 32'd0);
    chk("p4 cnt +1", 32'(cnt), 32'(cnt_before) + 1);
    tick();
    drive("p4 fwd", 0, 0, 0, 0, 2'b00, 0);
    chk("p4 fwd_b wb", 32'(fb), 32'd1);
    tick();

    // Branch flush: E becomes a bubble; branch overrides a load-use stall
    step("p5 br", 0, 0, 9, 1, 2'b00, 1);
    step("p5 nxt", 9, 0, 0, 0, 2'b00, 0);
    drive("p5 bub", 0, 0, 0, 0, 2'b00, 0);
    chk("p5 no fwd from bubble", 32'(fa), 32'd0);
    tick();
    step("p5 ld", 0, 0, 4, 1, 2'b01, 0);
    drive("p5 ld+br", 4, 0, 0, 0, 2'b00, 1);
    chk("p5 stall_d", 32'(sd), 32'd0);
    chk("p5 flush_e", 32'(fe), 32'd1);
    tick();

    // Reset during a load-use stall takes effect without a clock edge
    step("p1 ld", 0, 0, 3, 1, 2'b01, 0);
    drive("p1 use", 3, 0, 0, 0, 2'b00, 0);
    #2;
    reset = 1'b1;
    #1;
    model_clear();
    chk("p1 async stall_f", 32'(sf), 32'd0);
    chk("p1 async stall_d", 32'(sd), 32'd0);
    chk("p1 async cnt", 32'(cnt), 32'd0);
    check_outputs("p1 in reset");
    @(posedge clk); #1;
    reset = 1'b0;
    drive("p1 after", 0, 0, 0, 0, 2'b00, 0);
    chk("p1 fwd_a", 32'(fa), 32'd0);
    chk("p1 fwd_b", 32'(fb), 32'd0);
    tick();

    // Nine load-use stalls: 3-bit counter saturates at 7
    for (int i = 0; i < 9; i++) begin
      step("p6 ld", 0, 0, 2, 1, 2'b01, 0);
      step("p6 use", 2, 0, 0, 0, 2'b00, 0);
      step("p6 held", 2, 0, 0, 0, 2'b00, 0);
    end
    drive("p6 end", 0, 0, 0, 0, 2'b00, 0);
    chk("p6 cnt3 sat", 32'(cnt3), 32'd7);
    chk("p6 cnt16", 32'(cnt), 32'd9);
    tick();

    // Random traffic over a small register range to provoke hazards
    for (int i = 0; i < 1500; i++) begin
      logic [1:0] rs;
      rs = ($urandom_range(0, 2) == 0) ? 2'b01 : 2'($urandom_range(0, 3));
      step("rand", 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
           5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), rs,
           ($urandom_range(0, 9) == 0));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule : tb_hazard_fwd_ctrl

// File: doc/hazard_fwd_ctrl.md
Name: hazard_fwd_ctrl

Overview:
Pipeline hazard and forwarding controller for the 5-stage RISC-V core. It is the producer side of the 3-input forwarding muxes in EX: it generates their 2-bit selects, where s[1] has priority over s[0]. It keeps its own shadow copy of the E/M/W destination-register state, detects load-use hazards, and generates stall and flush controls for the F/D/E pipeline registers. It also maintains a saturating stall-cycle counter for performance monitoring.

Parameters:
REG_AW, 5, register address width
CNT_W, 16, stall counter width

Ports:
clk  in  1  core clock
reset  in  1  asynchronous, active-high reset
rs1_d  in  REG_AW  source reg 1 of instruction in D
rs2_d  in  REG_AW  source reg 2 of instruction in D
rd_d  in  REG_AW  destination reg of instruction in D
regwrite_d  in  1  D instruction writes the register file
resultsrc_d  in  2  D result source; RESULT_LOAD (2'b01) marks a load
pc_src_e  in  1  taken branch/jump resolved in EX
forward_a_e  out  2  select for the EX operand-A mux
forward_b_e  out  2  select for the EX operand-B mux
stall_f  out  1  hold PC
stall_d  out  1  hold IF/ID register
flush_d  out  1  clear IF/ID register
flush_e  out  1  clear ID/EX register
stall_cnt  out  CNT_W  saturating count of stalled cycles

Behaviour:
- Reset is asynchronous and active-high. All internal state clears to 0: rs1_e, rs2_e, rd_e, regwrite_e, load_e, rd_m, regwrite_m, rd_w, regwrite_w, stall_cnt.
- During and after reset, forward_*_e = 2'b00, stall_f = stall_d = 0, stall_cnt = 0.
- During and after reset, flush_d and flush_e follow the combinational equations below.
- Shadow pipeline, updated on the clk rising edge:
  - M->W always shifts (rd_w <= rd_m, regwrite_w <= regwrite_m).
  - E->M always shifts.
  - D->E: if flush_e, insert a bubble (rd_e = 0, regwrite_e = 0, load_e = 0, rs1_e = 0, rs2_e = 0). Otherwise capture the D inputs, with load_e = (resultsrc_d == RESULT_LOAD).
  - flush_e takes precedence over stall_d for the E capture.
- Forwarding is combinational from registered state only, so it adds 0 cycles of latency. For X in {a: rs1_e, b: rs2_e}:
  - FWD_MEM (2'b10) if rsX_e != 0 and rsX_e == rd_m and regwrite_m.
  - else FWD_WB (2'b01) if rsX_e != 0 and rsX_e == rd_w and regwrite_w.
  - else FWD_RF (2'b00).
  - M beats W when both match. x0 never forwards.
- Load-use condition: lw_stall = load_e and rd_e != 0 and (rs1_d == rd_e or rs2_d == rd_e).
  - Matching is on rs1_d/rs2_d regardless of whether the D instruction actually uses them.
- Control outputs (combinational):
  - stall_f = stall_d = lw_stall and not pc_src_e. The D instruction is killed anyway when a branch is taken.
  - flush_d = pc_src_e.
  - flush_e = lw_stall or pc_src_e.
- A stall lasts exactly 1 cycle per load-use hazard, because the bubble clears load_e on the next edge. Back-to-back dependent loads each stall once.
- stall_cnt increments on every edge where stall_d = 1 and saturates at 2^CNT_W - 1 (no wrap).
- Reset asserted mid-stall: stall deasserts asynchronously, all shadow state clears, and stall_cnt returns to 0.

Decomposition:
- Shared package core_pkg holds:
  - fwd_sel_t enum: FWD_RF = 2'b00, FWD_WB = 2'b01, FWD_MEM = 2'b10. It is shared with the EX forwarding muxes.
  - RESULT_LOAD = 2'b01.
  - REG_AW default.
- One natural sub-module, hazard_shadow_pipe: the D->E->M->W rd/regwrite/load shadow registers with bubble insert.
- Forwarding, stall logic and the counter stay in the top module.

Test Plan:
1. Reset mid-stream: assert reset during a load-use stall -> all outputs return to 0 immediately without waiting for a clk edge, stall_cnt = 0, and the next cycle's forwards are 2'b00.
2. EX/MEM forward: add x5 (rd=5, regwrite=1), then add using rs1=5 -> forward_a_e = 2'b10 in the dependent instruction's E cycle. A second dependent instruction 1 cycle later -> forward_a_e = 2'b01.
3. Double match: two successive writes to x7, then a read of x7 on rs2 -> forward_b_e = 2'b10 (the M result wins over W). A write to x0 followed by a read of x0 -> 2'b00.
4. Load-use: load with rd=3, then rs2_d=3 -> exactly 1 cycle of stall_f = stall_d = flush_e = 1, then forward_b_e = 2'b01 on the next cycle, and stall_cnt increments by 1.
5. Branch flush: pc_src_e = 1 for 1 cycle -> flush_d = flush_e = 1 and stall_* = 0. The next E stage is a bubble (no forward from it). With load_e and pc_src_e both set, stall_d = 0.
6. Counter saturation with CNT_W = 3: 9 load-use stalls -> stall_cnt stays at 7.
